// File: rtl/game_pkg.sv
// Shared types for the obstacle stream: field widths, obstacle word layout and FSM states.
package game_pkg;

  localparam int unsigned TYPE_W                = 3;
  localparam int unsigned LANE_W                = 2;
  localparam int unsigned Z_W                   = 11;
  localparam int unsigned OBS_W                 = TYPE_W + LANE_W + Z_W;
  localparam int unsigned HALF_BLOCK_LENGTH_DEF = 64;

  typedef enum logic [TYPE_W-1:0] {
    ObsNone   = 3'd0,
    ObsLow    = 3'd1,
    ObsHigh   = 3'd2,
    ObsMid    = 3'd3,
    ObsTrain  = 3'd4,
    ObsRamp   = 3'd5,
    ObsMoving = 3'd6
  } obstacle_type_e;

  typedef struct packed {
    logic [TYPE_W-1:0] typ;
    logic [LANE_W-1:0] lane;
    logic [Z_W-1:0]    z;
  } obstacle_t;

  typedef enum logic [2:0] {
    StIdle,
    StAdvance,
    StRetire,
    StEmit,
    StDone
  } state_e;

  // Move an obstacle closer by speed, saturating at zero.
  function automatic logic [Z_W-1:0] advance_z(input logic [Z_W-1:0] z,
                                               input int unsigned speed);
    if (32'(z) >= speed) return z - Z_W'(speed);
    return '0;
  endfunction

endpackage

// File: rtl/obstacle_streamer_if.sv
// Spawn handshake and obstacle stream bundle; master is the streamer side.
interface obstacle_streamer_if
  import game_pkg::*;
;
  logic              spawn_valid;
  logic              spawn_ready;
  logic [TYPE_W-1:0] spawn_type;
  logic [LANE_W-1:0] spawn_lane;
  logic [OBS_W-1:0]  obstacle;
  logic              obstacle_valid;
  logic              firstrow;

  modport master (
    input  spawn_valid, spawn_type, spawn_lane,
    output spawn_ready, obstacle, obstacle_valid, firstrow
  );

  modport slave (
    output spawn_valid, spawn_type, spawn_lane,
    input  spawn_ready, obstacle, obstacle_valid, firstrow
  );
endinterface

// File: rtl/obstacle_ring.sv
// Circular obstacle buffer: one write port, one combinational read port, head/tail/occupancy.
module obstacle_ring
  import game_pkg::*;
#(
  parameter  int unsigned MAX_OBSTACLES = 16,
  localparam int unsigned PTR_W         = $clog2(MAX_OBSTACLES),
  localparam int unsigned OCC_W         = $clog2(MAX_OBSTACLES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic [PTR_W-1:0] i_waddr,
  input  obstacle_t        i_wdata,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [PTR_W-1:0] i_raddr,
  output obstacle_t        o_rdata,
  output logic [PTR_W-1:0] o_head,
  output logic [PTR_W-1:0] o_tail,
  output logic [OCC_W-1:0] o_occupancy
);

  obstacle_t        r_mem [MAX_OBSTACLES];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [OCC_W-1:0] r_occ;

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else begin
      if (i_push) r_tail <= r_tail + PTR_W'(1);
      if (i_pop)  r_head <= r_head + PTR_W'(1);
      if (i_push && !i_pop)      r_occ <= r_occ + OCC_W'(1);
      else if (i_pop && !i_push) r_occ <= r_occ - OCC_W'(1);
    end
  end

  assign o_rdata     = r_mem[i_raddr];
  assign o_head      = r_head;
  assign o_tail      = r_tail;
  assign o_occupancy = r_occ;

endmodule

// File: rtl/obstacle_streamer.sv
// Per-frame obstacle producer: accepts spawns, then advances, retires and emits each live entry.
module obstacle_streamer
  import game_pkg::*;
#(
  parameter  int unsigned MAX_OBSTACLES     = 16,
  parameter  int unsigned HALF_BLOCK_LENGTH = HALF_BLOCK_LENGTH_DEF,
  parameter  int unsigned SPEED             = 1,
  parameter  int unsigned SPAWN_DISTANCE    = 1023,
  localparam int unsigned PTR_W             = $clog2(MAX_OBSTACLES),
  localparam int unsigned OCC_W             = $clog2(MAX_OBSTACLES + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_new_frame,
  input  logic                 i_freeze,
  obstacle_streamer_if.master  io_stream,
  output logic                 o_frame_done,
  output logic [OCC_W-1:0]     o_occupancy,
  output logic                 o_busy,
  output logic                 o_overrun
);

  state_e           r_state, w_state_next;
  logic [PTR_W-1:0] r_idx, w_idx_next;
  logic [OCC_W-1:0] r_cnt, w_cnt_next;
  obstacle_t        r_obstacle;
  logic             r_obstacle_valid, r_firstrow, r_overrun;

  logic             w_we, w_push, w_pop, w_emit;
  logic [PTR_W-1:0] w_waddr, w_raddr, w_head, w_tail;
  obstacle_t        w_wdata, w_rdata;
  logic [OCC_W-1:0] w_occ, w_occ_eff;
  logic             w_spawn_ready, w_spawn_write;

  obstacle_ring #(
    .MAX_OBSTACLES(MAX_OBSTACLES)
  ) u_ring (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_we       (w_we),
    .i_waddr    (w_waddr),
    .i_wdata    (w_wdata),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_raddr    (w_raddr),
    .o_rdata    (w_rdata),
    .o_head     (w_head),
    .o_tail     (w_tail),
    .o_occupancy(w_occ)
  );

  assign w_spawn_ready = (r_state == StIdle) && (w_occ < OCC_W'(MAX_OBSTACLES));
  // Lane 3 completes the handshake but never lands in the buffer.
  assign w_spawn_write = io_stream.spawn_valid && w_spawn_ready && (io_stream.spawn_lane != 2'd3);
  // A spawn landing with new_frame is part of that frame.
  assign w_occ_eff     = w_occ + OCC_W'(w_spawn_write);

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_cnt_next   = r_cnt;
    w_we         = 1'b0;
    w_waddr      = w_tail;
    w_wdata      = w_rdata;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_raddr      = r_idx;
    w_emit       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_spawn_write) begin
          w_we          = 1'b1;
          w_push        = 1'b1;
          w_wdata.typ   = io_stream.spawn_type;
          w_wdata.lane  = io_stream.spawn_lane;
          w_wdata.z     = Z_W'(SPAWN_DISTANCE);
        end
        if (i_new_frame) begin
          w_idx_next = w_head;
          w_cnt_next = w_occ_eff;
          if (w_occ_eff == '0) w_state_next = StDone;
          else if (i_freeze)   w_state_next = StEmit;
          else                 w_state_next = StAdvance;
        end
      end
      StAdvance: begin
        w_we       = 1'b1;
        w_waddr    = r_idx;
        w_wdata.z  = advance_z(w_rdata.z, SPEED);
        w_idx_next = r_idx + PTR_W'(1);
        w_cnt_next = r_cnt - OCC_W'(1);
        if (r_cnt == OCC_W'(1)) w_state_next = StRetire;
      end
      StRetire: begin
        w_raddr = w_head;
        if (w_occ != '0 && w_rdata.z == '0) begin
          w_pop = 1'b1;
        end else begin
          w_idx_next   = w_head;
          w_cnt_next   = w_occ;
          w_state_next = (w_occ != '0) ? StEmit : StDone;
        end
      end
      StEmit: begin
        w_emit     = 1'b1;
        w_idx_next = r_idx + PTR_W'(1);
        w_cnt_next = r_cnt - OCC_W'(1);
        if (r_cnt == OCC_W'(1)) w_state_next = StDone;
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= StIdle;
      r_idx            <= '0;
      r_cnt            <= '0;
      r_obstacle       <= '0;
      r_obstacle_valid <= 1'b0;
      r_firstrow       <= 1'b0;
      r_overrun        <= 1'b0;
    end else begin
      r_state          <= w_state_next;
      r_idx            <= w_idx_next;
      r_cnt            <= w_cnt_next;
      r_obstacle_valid <= w_emit;
      r_firstrow       <= w_emit && (32'(w_rdata.z) <= HALF_BLOCK_LENGTH);
      if (w_emit) r_obstacle <= w_rdata;
      if (i_new_frame && r_state != StIdle) r_overrun <= 1'b1;
    end
  end

  assign io_stream.spawn_ready    = w_spawn_ready;
  assign io_stream.obstacle       = r_obstacle;
  assign io_stream.obstacle_valid = r_obstacle_valid;
  assign io_stream.firstrow       = r_firstrow;
  assign o_frame_done             = (r_state == StDone);
  assign o_occupancy              = w_occ;
  assign o_busy                   = (r_state != StIdle);
  assign o_overrun                = r_overrun;

endmodule

// File: tb/tb_obstacle_streamer.sv
// Directed and randomized stimulus for obstacle_streamer, checked against a queue-based frame model.
module tb_obstacle_streamer;
  import game_pkg::*;

  localparam int MAXO    = 16;
  localparam int HBL     = 64;
  localparam int SPD     = 1;
  localparam int SPAWN_Z = 1023;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       new_frame = 1'b0;
  logic       freeze = 1'b0;
  logic       frame_done, busy, overrun;
  logic [4:0] occupancy;

  obstacle_streamer_if bus ();

  obstacle_streamer #(
    .MAX_OBSTACLES    (MAXO),
    .HALF_BLOCK_LENGTH(HBL),
    .SPEED            (SPD),
    .SPAWN_DISTANCE   (SPAWN_Z)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_new_frame (new_frame),
    .i_freeze    (freeze),
    .io_stream   (bus),
    .o_frame_done(frame_done),
    .o_occupancy (occupancy),
    .o_busy      (busy),
    .o_overrun   (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int typ;
    int lane;
    int z;
  } ent_t;

  ent_t        model_q[$];
  int          n_vec = 0;
  int          n_fail = 0;
  int          last_lat, last_emits;
  logic [15:0] first_word;
  logic        first_fr;
  logic        held = 1'b0;
  ent_t        held_e;

  function automatic logic [15:0] word_of(input ent_t e);
    return {3'(e.typ), 2'(e.lane), 11'(e.z)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    new_frame = 1'b0;
    bus.spawn_valid = 1'b0;
    held = 1'b0;
    @(posedge clk); #1;
    chk("rst_obstacle", 32'(bus.obstacle), 32'(0));
    chk("rst_valid", 32'(bus.obstacle_valid), 32'(0));
    chk("rst_firstrow", 32'(bus.firstrow), 32'(0));
    chk("rst_frame_done", 32'(frame_done), 32'(0));
    chk("rst_occupancy", 32'(occupancy), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_overrun", 32'(overrun), 32'(0));
    rst_n = 1'b1;
    model_q.delete();
    @(posedge clk); #1;
    chk("rst_spawn_ready", 32'(bus.spawn_ready), 32'(1));
  endtask

  task automatic spawn(input int typ, input int lane);
    int waitc = 0;
    bus.spawn_type  = 3'(typ);
    bus.spawn_lane  = 2'(lane);
    bus.spawn_valid = 1'b1;
    while (!bus.spawn_ready && waitc < 200) begin
      @(posedge clk); #1;
      waitc++;
    end
    chk("spawn_ready_wait", 32'(waitc >= 200), 32'(0));
    @(posedge clk); #1;
    bus.spawn_valid = 1'b0;
    if (waitc < 200 && lane != 3) model_q.push_back('{typ, lane, SPAWN_Z});
    chk("occ_after_spawn", 32'(occupancy), 32'(model_q.size()));
  endtask

  // inject_at / reset_at: cycle (counted from the new_frame edge) for a stray new_frame / reset.
  task automatic run_frame(input logic frz, input int inject_at, input int reset_at);
    ent_t exp_q[$];
    int   n, r, exp_lat, k, idx;
    logic seen_done;
    if (held && model_q.size() < MAXO) begin
      model_q.push_back(held_e);
      held = 1'b0;
    end
    n = model_q.size();
    r = 0;
    if (!frz) begin
      foreach (model_q[i]) model_q[i].z = (model_q[i].z >= SPD) ? model_q[i].z - SPD : 0;
      while (model_q.size() > 0 && model_q[0].z == 0) begin
        void'(model_q.pop_front());
        r++;
      end
    end
    exp_q = model_q;
    if (n == 0)   exp_lat = 1;
    else if (frz) exp_lat = n + 1;
    else          exp_lat = (n + r + 1) + (n - r) + 1;

    freeze = frz;
    new_frame = 1'b1;
    @(posedge clk); #1;
    new_frame = 1'b0;
    if (!held) bus.spawn_valid = 1'b0;
    idx = 0;
    seen_done = 1'b0;
    k = 1;
    while (!seen_done && k <= 300) begin
      if (k == reset_at) begin
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(bus.obstacle_valid), 32'(0));
        chk("midrst_occupancy", 32'(occupancy), 32'(0));
        chk("midrst_busy", 32'(busy), 32'(0));
        #1;
        rst_n = 1'b1;
        model_q.delete();
        return;
      end
      if (bus.obstacle_valid) begin
        if (idx < exp_q.size()) begin
          chk("obstacle_word", 32'(bus.obstacle), 32'(word_of(exp_q[idx])));
          chk("firstrow", 32'(bus.firstrow), 32'(exp_q[idx].z <= HBL));
        end else begin
          chk("emit_overflow", 32'(idx), 32'(exp_q.size()));
        end
        if (idx == 0) begin
          first_word = bus.obstacle;
          first_fr   = bus.firstrow;
        end
        idx++;
      end else begin
        chk("firstrow_idle", 32'(bus.firstrow), 32'(0));
      end
      new_frame = (k == inject_at);
      if (frame_done) seen_done = 1'b1;
      else begin
        @(posedge clk); #1;
        k++;
      end
    end
    new_frame = 1'b0;
    last_lat = k;
    last_emits = idx;
    chk("frame_done_latency", 32'(k), 32'(exp_lat));
    chk("emit_count", 32'(idx), 32'(exp_q.size()));
    chk("occupancy", 32'(occupancy), 32'(model_q.size()));
    @(posedge clk); #1;
    chk("frame_done_pulse", 32'(frame_done), 32'(0));
    chk("busy_after", 32'(busy), 32'(0));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.spawn_valid = 1'b0;
    bus.spawn_type  = '0;
    bus.spawn_lane  = '0;
    do_reset();

    // Single entry, first frame, then walk it all the way to retirement.
    spawn(4, 1);
    run_frame(1'b0, 0, 0);
    chk("first_word", 32'(first_word), 32'h8BFE);
    chk("first_firstrow", 32'(first_fr), 32'(0));
    chk("first_latency", 32'(last_lat), 32'(4));
    for (int f = 0; f < 1022; f++) begin
      run_frame(1'b0, 0, 0);
      if (f == 956) begin
        chk("z65_word", 32'(first_word), 32'({3'd4, 2'd1, 11'd65}));
        chk("z65_firstrow", 32'(first_fr), 32'(0));
      end
      if (f == 957) begin
        chk("z64_word", 32'(first_word), 32'({3'd4, 2'd1, 11'd64}));
        chk("z64_firstrow", 32'(first_fr), 32'(1));
      end
    end
    chk("retire_emits", 32'(last_emits), 32'(0));
    chk("retire_occupancy", 32'(occupancy), 32'(0));

    // Fill to capacity and hold a 17th spawn until the oldest entry retires.
    do_reset();
    spawn($urandom_range(1, 6), $urandom_range(0, 2));
    for (int f = 0; f < 600; f++) run_frame(1'b0, 0, 0);
    for (int s = 0; s < 15; s++) spawn($urandom_range(1, 6), $urandom_range(0, 2));
    chk("full_occupancy", 32'(occupancy), 32'(16));
    chk("full_ready", 32'(bus.spawn_ready), 32'(0));
    held_e = '{6, 2, SPAWN_Z};
    held = 1'b1;
    bus.spawn_type  = 3'd6;
    bus.spawn_lane  = 2'd2;
    bus.spawn_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("held_occupancy", 32'(occupancy), 32'(16));
    chk("held_ready", 32'(bus.spawn_ready), 32'(0));
    for (int f = 0; f < 500 && held; f++) run_frame(1'b0, 0, 0);
    chk("held_accepted_occ", 32'(occupancy), 32'(16));

    // Frozen frame, overrun during EMIT, then reset mid-EMIT.
    do_reset();
    for (int s = 0; s < 3; s++) spawn($urandom_range(1, 6), $urandom_range(0, 2));
    for (int f = 0; f < 523; f++) run_frame(1'b0, 0, 0);
    run_frame(1'b1, 0, 0);
    chk("freeze_z", 32'(first_word[10:0]), 32'(500));
    chk("freeze_emits", 32'(last_emits), 32'(3));
    chk("freeze_latency", 32'(last_lat), 32'(4));
    chk("overrun_before", 32'(overrun), 32'(0));
    run_frame(1'b1, 2, 0);
    chk("overrun_after", 32'(overrun), 32'(1));
    chk("overrun_latency", 32'(last_lat), 32'(4));
    run_frame(1'b1, 0, 2);
    run_frame(1'b0, 0, 0);
    chk("post_reset_emits", 32'(last_emits), 32'(0));
    chk("post_reset_latency", 32'(last_lat), 32'(1));
    chk("post_reset_overrun", 32'(overrun), 32'(0));

    // Randomized spawns (lane 3 included) and freeze pattern.
    for (int f = 0; f < 40; f++) begin
      int nsp;
      nsp = $urandom_range(0, 2);
      for (int s = 0; s < nsp; s++)
        if (model_q.size() < MAXO) spawn($urandom_range(1, 6), $urandom_range(0, 3));
      run_frame($urandom_range(0, 3) == 0, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
